// File: rtl/crc_multi_arb.sv
// N-channel round-robin arbiter in front of one shared MSB-first CRC engine.
// Define CRC_ARB_TIMEOUT_EN to force-release an owner that stays idle for HOLD_MAX cycles.
module crc_multi_arb #(
  parameter int unsigned      N_CH     = 2,
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      CRC_W    = 16,
  parameter logic [CRC_W-1:0] POLY     = 16'h1021,
  parameter logic [CRC_W-1:0] INIT     = 16'hFFFF,
  parameter int unsigned      HOLD_MAX = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          rel,
  input  logic [N_CH-1:0]          init,
  input  logic [N_CH*DATA_W-1:0]   data,
  input  logic [N_CH-1:0]          dv,
  output logic [N_CH-1:0]          grant,
  output logic                     busy,
  output logic [CRC_W-1:0]         crc_out,
  output logic [N_CH-1:0]          drop,
  output logic                     timeout
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_OWNED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [N_CH-1:0]   drop_q, drop_d;
  logic              own_init, own_dv, own_rel, own_req, to_hit;
  logic [DATA_W-1:0] own_data;
  logic              found;
  logic [IDX_W-1:0]  pick;

  // One unrolled LFSR pass over DATA_W bits, MSB first.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      fb = c[CRC_W-1] ^ d[b];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // grant_q is one-hot of the owner (zero in IDLE), so it doubles as the owner mask.
  assign own_init = |(init & grant_q);
  assign own_dv   = |(dv & grant_q);
  assign own_rel  = |(rel & grant_q);
  assign own_req  = |(req & grant_q);

  always_comb begin
    own_data = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      own_data = own_data | (data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
    end
  end

  // First requesting channel at or after the round-robin pointer.
  always_comb begin
    int unsigned cand;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = (32'(rr_q) + i) % N_CH;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  // Idle counter only runs while owned; cleared by strobes and while idle.
  always_comb begin
    cnt_d  = '0;
    to_hit = 1'b0;
    if (state_q == S_OWNED && !(own_init || own_dv)) begin
      cnt_d  = (cnt_q == CNT_W'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
      to_hit = (cnt_d == CNT_W'(HOLD_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= to_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    crc_d   = crc_q;
    drop_d  = (init | dv) & ~grant_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_OWNED;
          grant_d = N_CH'(1) << pick;
          busy_d  = 1'b1;
          rr_d    = (pick == IDX_W'(N_CH - 1)) ? '0 : pick + 1'b1;
        end
      end
      S_OWNED: begin
        if (own_dv) begin
          crc_d = crc_step(own_init ? INIT : crc_q, own_data);
        end else if (own_init) begin
          crc_d = INIT;
        end
        if (own_rel || !own_req || to_hit) begin
          state_d = S_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
      crc_q   <= INIT;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      crc_q   <= crc_d;
      drop_q  <= drop_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign crc_out = crc_q;
  assign drop    = drop_q;

endmodule

// File: tb/tb_crc_multi_arb.sv
// Directed bench for crc_multi_arb: 2 channels, CRC-16/CCITT-FALSE, HOLD_MAX=4.
module tb_crc_multi_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, rel, init, dv;
  logic [15:0] data;
  logic [1:0]  grant, drop;
  logic        busy, timeout;
  logic [15:0] crc_out;

  int checks;
  int failures;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  crc_multi_arb #(
    .N_CH(2), .DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .HOLD_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .init(init), .data(data), .dv(dv),
    .grant(grant), .busy(busy), .crc_out(crc_out), .drop(drop), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; rel = '0; init = '0; dv = '0; data = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (crc_out !== 16'hFFFF) begin failures++; $display("FAIL reset_crc got=%h exp=ffff", crc_out); end
    checks++;
    if (drop !== 2'b00 || timeout !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got drop=%b timeout=%b exp 00/0", drop, timeout);
    end
  endtask

  task automatic test_crc_ascii();
    req = 2'b01;
    step();
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      failures++; $display("FAIL ascii_grant got grant=%b busy=%b exp 01/1", grant, busy);
    end
    init = 2'b01;
    step();
    init = 2'b00;
    for (int i = 0; i < 9; i++) begin
      dv = 2'b01;
      data = {8'h00, msg[i]};
      step();
    end
    dv = 2'b00;
    checks++;
    if (crc_out !== 16'h29B1) begin failures++; $display("FAIL ascii_crc got=%h exp=29b1", crc_out); end
    checks++;
    if (drop !== 2'b00) begin failures++; $display("FAIL ascii_drop got=%b exp=00", drop); end
    rel = 2'b01;
    req = 2'b00;
    step();
    rel = 2'b00;
    checks++;
    if (grant !== 2'b00 || crc_out !== 16'h29B1) begin
      failures++; $display("FAIL ascii_release got grant=%b crc=%h exp 00/29b1", grant, crc_out);
    end
    step();
  endtask

  task automatic test_rr();
    do_reset();
    req = 2'b11;
    step();
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", grant); end
    rel = 2'b01;
    req = 2'b10;
    step();
    rel = 2'b00;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL rr_dead got grant=%b busy=%b exp 00/0", grant, busy);
    end
    step();
    checks++;
    if (grant !== 2'b10) begin failures++; $display("FAIL rr_second got=%b exp=10", grant); end
    req = 2'b00;
    step();
    step();
  endtask

  task automatic test_block();
    req = 2'b01;
    step();
    init = 2'b01;
    step();
    init = 2'b00;
    dv = 2'b10;
    data = 16'hA500;
    step();
    dv = 2'b00;
    checks++;
    if (crc_out !== 16'hFFFF || drop !== 2'b10) begin
      failures++; $display("FAIL block_dv got crc=%h drop=%b exp ffff/10", crc_out, drop);
    end
    step();
    checks++;
    if (drop !== 2'b00 || grant !== 2'b01) begin
      failures++; $display("FAIL block_pulse got drop=%b grant=%b exp 00/01", drop, grant);
    end
  endtask

  task automatic test_init_dv();
    init = 2'b01;
    dv = 2'b01;
    data = 16'h0000;
    step();
    init = 2'b00;
    dv = 2'b00;
    checks++;
    if (crc_out !== 16'hE1F0) begin failures++; $display("FAIL init_dv got=%h exp=e1f0", crc_out); end
  endtask

  task automatic test_dv_rel();
    init = 2'b01;
    step();
    init = 2'b00;
    dv = 2'b01;
    rel = 2'b01;
    data = 16'h0031;
    step();
    dv = 2'b00;
    rel = 2'b00;
    checks++;
    if (crc_out !== 16'hC782 || grant !== 2'b00) begin
      failures++; $display("FAIL dv_rel got crc=%h grant=%b exp c782/00", crc_out, grant);
    end
    // Dead cycle: ch0 still requesting, its init must be blocked and flagged.
    init = 2'b01;
    step();
    init = 2'b00;
    checks++;
    if (drop !== 2'b01 || crc_out !== 16'hC782 || grant !== 2'b01) begin
      failures++;
      $display("FAIL dead_drop got drop=%b crc=%h grant=%b exp 01/c782/01", drop, crc_out, grant);
    end
    req = 2'b00;
    step();
    step();
  endtask

  task automatic test_req_drop_grant_cycle();
    req = 2'b10;
    step();
    checks++;
    if (grant !== 2'b10) begin failures++; $display("FAIL reqdrop_grant got=%b exp=10", grant); end
    req = 2'b00;
    step();
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL reqdrop_release got grant=%b busy=%b exp 00/0", grant, busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req = 2'b01;
    step();
    init = 2'b01;
    dv = 2'b01;
    data = 16'h0055;
    step();
    init = 2'b00;
    dv = 2'b00;
    rst_n = 1'b0;
    req = 2'b11;
    step();
    checks++;
    if (crc_out !== 16'hFFFF || grant !== 2'b00) begin
      failures++; $display("FAIL reset_mid got crc=%h grant=%b exp ffff/00", crc_out, grant);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL reset_rr got=%b exp=01", grant); end
    req = 2'b00;
    step();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 2'b10;
    step();
    checks++;
    if (grant !== 2'b10) begin failures++; $display("FAIL to_grant got=%b exp=10", grant); end
`ifdef CRC_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (grant !== 2'b10 || timeout !== 1'b0) begin
        failures++; $display("FAIL to_hold%0d got grant=%b timeout=%b exp 10/0", i, grant, timeout);
      end
    end
    step();
    checks++;
    if (grant !== 2'b00 || timeout !== 1'b1) begin
      failures++; $display("FAIL to_fire got grant=%b timeout=%b exp 00/1", grant, timeout);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b exp=0", timeout); end
`else
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (grant !== 2'b10 || timeout !== 1'b0) begin
        failures++; $display("FAIL no_to%0d got grant=%b timeout=%b exp 10/0", i, grant, timeout);
      end
    end
`endif
    rst_n = 1'b0;
    step();
    checks++;
    if (crc_out !== 16'hFFFF || grant !== 2'b00) begin
      failures++; $display("FAIL to_reset got crc=%h grant=%b exp ffff/00", crc_out, grant);
    end
    rst_n = 1'b1;
    req = 2'b00;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_crc_ascii();
    test_rr();
    test_block();
    test_init_dv();
    test_dv_rel();
    test_req_drop_grant_cycle();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
